// File: rtl/icache_if.sv
// Fetch-side bus of the instruction cache: the IF request/response pair plus the
// mem_ctrl instruction port. The cache uses the slave view; IF/mem_ctrl use master.
interface icache_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        mc_enable;
  logic [31:0] mc_addr;
  logic [31:0] mc_inst;
  logic        mc_finished;

  modport slave (
    input  if_req, if_addr, mc_inst, mc_finished,
    output if_ready, if_valid, if_inst, mc_enable, mc_addr
  );

  modport master (
    output if_req, if_addr, mc_inst, mc_finished,
    input  if_ready, if_valid, if_inst, mc_enable, mc_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and mem_ctrl.
// Hits answer from the line array; misses fetch one word through mem_ctrl and fill.
module icache #(
  parameter int INDEX_W = 8
) (
  input logic     clk,
  input logic     rst,
  input logic     rdy,
  input logic     flush,
  icache_if.slave bus
);
  localparam int LINES = 2 ** INDEX_W;
  localparam int TAG_W = 16 - INDEX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS} state_t;

  state_t             state, state_next;
  logic [29:0]        req_word;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];
  logic               flushed;
  logic               if_valid_q, if_valid_n;
  logic [31:0]        if_inst_q, if_inst_n;
  logic               mc_enable_q, mc_enable_n;
  logic [31:0]        mc_addr_q, mc_addr_n;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               fill;
  logic               unused_addr_bits;

  assign idx  = req_word[INDEX_W-1:0];
  assign tag  = req_word[15:INDEX_W];
  // A flush arriving during the lookup must not let the old line answer.
  assign hit  = valid[idx] && (tag_mem[idx] == tag) && !flush;
  assign fill = (state == MISS) && bus.mc_finished;
  assign unused_addr_bits = ^bus.if_addr[1:0];

  assign bus.if_ready  = (state == IDLE);
  assign bus.if_valid  = if_valid_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.mc_enable = mc_enable_q;
  assign bus.mc_addr   = mc_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.if_req) state_next = LOOKUP;
      LOOKUP:  state_next = hit ? IDLE : MISS;
      MISS:    if (bus.mc_finished) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    if_valid_n  = 1'b0;
    if_inst_n   = if_inst_q;
    mc_enable_n = mc_enable_q;
    mc_addr_n   = mc_addr_q;
    case (state)
      LOOKUP: begin
        if (hit) begin
          if_valid_n = 1'b1;
          if_inst_n  = data_mem[idx];
        end else begin
          mc_enable_n = 1'b1;
          mc_addr_n   = {req_word, 2'b00};
        end
      end
      MISS: begin
        if (bus.mc_finished) begin
          mc_enable_n = 1'b0;
          if_valid_n  = 1'b1;
          if_inst_n   = bus.mc_inst;
        end
      end
      default: ;
    endcase
  end

  // A flush seen while the miss is outstanding keeps the refilled line invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_word    <= '0;
      valid       <= '0;
      flushed     <= 1'b0;
      if_valid_q  <= 1'b0;
      if_inst_q   <= '0;
      mc_enable_q <= 1'b0;
      mc_addr_q   <= '0;
    end else if (rdy) begin
      if (state == IDLE && bus.if_req) req_word <= bus.if_addr[31:2];
      if (flush) valid <= '0;
      else if (fill && !flushed) valid[idx] <= 1'b1;
      if (state != MISS) flushed <= 1'b0;
      else if (flush) flushed <= 1'b1;
      if_valid_q  <= if_valid_n;
      if_inst_q   <= if_inst_n;
      mc_enable_q <= mc_enable_n;
      mc_addr_q   <= mc_addr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= bus.mc_inst;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a line-level cache model predicts every cycle's
// outputs, and literal expectations pin latencies, miss/hit outcomes and returned words.
module tb_icache;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;

  icache_if bus ();

  icache #(.INDEX_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic        exp_ready, exp_valid, exp_mc_en;
  logic [31:0] exp_inst, exp_mc_addr;
  logic        cmp_on = 1'b0;

  logic        m_valid [256];
  logic [7:0]  m_tag   [256];
  logic [31:0] m_data  [256];

  int          obs_e, obs_edges, obs_mc_cycles;
  logic        obs_miss;
  logic [31:0] obs_inst, obs_mc_addr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic modelHit(input logic [31:0] a);
    return m_valid[a[9:2]] && (m_tag[a[9:2]] == a[17:10]);
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("if_ready", bus.if_ready, exp_ready);
      checkOutput("if_valid", bus.if_valid, exp_valid);
      checkOutput("if_inst", bus.if_inst, exp_inst);
      checkOutput("mc_enable", bus.mc_enable, exp_mc_en);
      if (exp_mc_en) checkOutput("mc_addr", bus.mc_addr, exp_mc_addr);
    end
  end

  // Advance one edge and record what IF / mem_ctrl would see just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    obs_e++;
    if (bus.mc_enable) begin
      obs_miss = 1'b1;
      obs_mc_cycles++;
      obs_mc_addr = bus.mc_addr;
    end
    if (bus.if_valid && obs_edges == 0) begin
      obs_edges = obs_e;
      obs_inst  = bus.if_inst;
    end
  endtask

  // One fetch from an idle cache; flushAt: -1 none, 0 during lookup, k = k-th miss cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] word, input int lat,
                               input int stallLookup, input int stallMiss, input int flushAt);
    logic [7:0] idx;
    logic       hit;
    logic       flushedInMiss;
    idx = addr[9:2];
    hit = modelHit(addr) && (flushAt != 0);
    flushedInMiss = 1'b0;
    obs_e = 0; obs_edges = 0; obs_mc_cycles = 0; obs_miss = 1'b0;
    obs_inst = '0; obs_mc_addr = '0;
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    tick();
    bus.if_addr = addr ^ 32'h0000_0400;
    exp_ready = 1'b0;
    if (stallLookup > 0) begin
      rdy = 1'b0;
      repeat (stallLookup) tick();
      rdy = 1'b1;
    end
    flush = (flushAt == 0);
    tick();
    flush = 1'b0;
    if (flushAt == 0) clearModel();
    if (hit) begin
      exp_valid   = 1'b1;
      exp_inst    = m_data[idx];
      exp_ready   = 1'b1;
      bus.if_req  = 1'b0;
    end else begin
      exp_mc_en   = 1'b1;
      exp_mc_addr = {addr[31:2], 2'b00};
      if (stallMiss > 0) begin
        rdy = 1'b0;
        repeat (stallMiss) tick();
        rdy = 1'b1;
      end
      for (int k = 1; k <= lat; k++) begin
        flush           = (k == flushAt);
        bus.mc_finished = (k == lat);
        bus.mc_inst     = (k == lat) ? word : 32'hDEAD_BEEF;
        tick();
        if (flush) begin
          clearModel();
          flushedInMiss = 1'b1;
        end
        flush           = 1'b0;
        bus.mc_finished = 1'b0;
      end
      exp_mc_en  = 1'b0;
      exp_valid  = 1'b1;
      exp_inst   = word;
      exp_ready  = 1'b1;
      bus.if_req = 1'b0;
      m_tag[idx]   = addr[17:10];
      m_data[idx]  = word;
      m_valid[idx] = !flushedInMiss;
    end
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clearModel();
  endtask

  task automatic expectFetch(input string name, input logic miss, input logic [31:0] inst,
                             input int edges);
    checkOutput({name, "_miss"}, obs_miss, miss);
    checkOutput({name, "_inst"}, obs_inst, inst);
    checkOutput({name, "_edges"}, obs_edges, edges);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.mc_inst = '0; bus.mc_finished = 1'b0;
    clearModel();
    exp_ready = 1'b1; exp_valid = 1'b0; exp_inst = '0; exp_mc_en = 1'b0; exp_mc_addr = '0;
    cmp_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_if_ready", bus.if_ready, 1);
    checkOutput("reset_if_valid", bus.if_valid, 0);
    checkOutput("reset_if_inst", bus.if_inst, 0);
    checkOutput("reset_mc_enable", bus.mc_enable, 0);
    checkOutput("reset_mc_addr", bus.mc_addr, 0);
    rst = 1'b1;
    tick();

    $display("[TB] cold miss and hit");
    applyStimulus(32'h0000_0100, 32'h0000_0013, 4, 0, 0, -1);
    expectFetch("cold", 1'b1, 32'h13, 6);
    checkOutput("cold_mc_cycles", obs_mc_cycles, 4);
    checkOutput("cold_mc_addr", obs_mc_addr, 32'h100);
    checkOutput("model_hit_0x100", modelHit(32'h100), 1);
    applyStimulus(32'h0000_0100, 32'h0000_0000, 4, 0, 0, -1);
    expectFetch("hit", 1'b0, 32'h13, 2);
    checkOutput("hit_mc_cycles", obs_mc_cycles, 0);

    $display("[TB] conflict");
    pulseFlush();
    applyStimulus(32'h0000_0100, 32'hAAAA_AAAA, 2, 0, 0, -1);
    applyStimulus(32'h0000_0500, 32'hBBBB_BBBB, 2, 0, 0, -1);
    expectFetch("conflict_b", 1'b1, 32'hBBBB_BBBB, 4);
    checkOutput("model_evicted_0x100", modelHit(32'h100), 0);
    applyStimulus(32'h0000_0100, 32'hAAAA_AAAA, 3, 0, 0, -1);
    expectFetch("conflict_a", 1'b1, 32'hAAAA_AAAA, 5);
    checkOutput("conflict_mc_addr", obs_mc_addr, 32'h100);

    $display("[TB] flush");
    applyStimulus(32'h0000_0200, 32'h0000_2222, 3, 0, 0, -1);
    applyStimulus(32'h0000_0200, 32'h0, 3, 0, 0, -1);
    expectFetch("pre_flush_hit", 1'b0, 32'h2222, 2);
    pulseFlush();
    applyStimulus(32'h0000_0200, 32'h0000_2222, 3, 0, 0, -1);
    expectFetch("post_flush", 1'b1, 32'h2222, 5);
    applyStimulus(32'h0000_0300, 32'h0000_3333, 5, 0, 0, 2);
    expectFetch("flush_in_miss", 1'b1, 32'h3333, 7);
    applyStimulus(32'h0000_0300, 32'h0000_3333, 2, 0, 0, -1);
    expectFetch("after_flush_in_miss", 1'b1, 32'h3333, 4);
    applyStimulus(32'h0000_0300, 32'h0, 2, 0, 0, 0);
    expectFetch("flush_in_lookup", 1'b1, 32'h0, 4);
    applyStimulus(32'h0000_0304, 32'h0000_0044, 3, 0, 0, 3);
    applyStimulus(32'h0000_0304, 32'h0000_0044, 2, 0, 0, -1);
    expectFetch("flush_wins_fill", 1'b1, 32'h44, 4);

    $display("[TB] rdy stalls");
    applyStimulus(32'h0000_0600, 32'h0000_0066, 3, 0, 0, -1);
    expectFetch("nostall_miss", 1'b1, 32'h66, 5);
    applyStimulus(32'h0000_0600, 32'h0, 3, 3, 0, -1);
    expectFetch("stall_hit", 1'b0, 32'h66, 5);
    applyStimulus(32'h0000_0604, 32'h0000_0067, 3, 3, 3, -1);
    expectFetch("stall_miss", 1'b1, 32'h67, 11);
    checkOutput("stall_mc_cycles", obs_mc_cycles, 6);
    applyStimulus(32'h0004_0600, 32'h0, 3, 0, 0, -1);
    expectFetch("high_bits_ignored", 1'b0, 32'h66, 2);

    $display("[TB] reset mid-miss");
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0000_0700;
    tick();
    exp_ready = 1'b0;
    tick();
    exp_mc_en = 1'b1;
    exp_mc_addr = 32'h0000_0700;
    tick();
    #2;
    rst = 1'b0;
    bus.if_req = 1'b0;
    exp_ready = 1'b1; exp_valid = 1'b0; exp_inst = '0; exp_mc_en = 1'b0; exp_mc_addr = '0;
    clearModel();
    #1;
    checkOutput("rst_mid_miss_mc_enable", bus.mc_enable, 0);
    checkOutput("rst_mid_miss_if_ready", bus.if_ready, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    applyStimulus(32'h0000_0600, 32'h0000_0066, 2, 0, 0, -1);
    expectFetch("after_reset", 1'b1, 32'h66, 4);

    tick();
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
